// File: rtl/axi4_lite_cmd_mst.sv
// Command-driven AXI4-Lite master: takes one read/write command at a time, runs the
// bus transaction, returns the response and keeps a saturating count of error responses.
module axi4_lite_cmd_mst #(
  parameter int ADDR_BIT_WIDTH = 4,
  parameter int DATA_BIT_WIDTH = 32
) (
  input  logic                          i_clk,
  input  logic                          i_async_rst,
  // command port
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic                          i_cmd_is_wr,
  input  logic [ADDR_BIT_WIDTH-1:0]     i_cmd_addr,
  input  logic [DATA_BIT_WIDTH-1:0]     i_cmd_wdata,
  input  logic [DATA_BIT_WIDTH/8-1:0]   i_cmd_wstrb,
  // response port
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic                          o_rsp_is_wr,
  output logic [DATA_BIT_WIDTH-1:0]     o_rsp_rdata,
  output logic [1:0]                    o_rsp_resp,
  output logic [7:0]                    o_err_cnt,
  // AXI AW
  output logic [ADDR_BIT_WIDTH-1:0]     o_awaddr,
  output logic [2:0]                    o_awprot,
  output logic                          o_awvalid,
  input  logic                          i_awready,
  // AXI W
  output logic [DATA_BIT_WIDTH-1:0]     o_wdata,
  output logic [DATA_BIT_WIDTH/8-1:0]   o_wstrb,
  output logic                          o_wvalid,
  input  logic                          i_wready,
  // AXI B
  input  logic [1:0]                    i_bresp,
  input  logic                          i_bvalid,
  output logic                          o_bready,
  // AXI AR
  output logic [ADDR_BIT_WIDTH-1:0]     o_araddr,
  output logic [2:0]                    o_arprot,
  output logic                          o_arvalid,
  input  logic                          i_arready,
  // AXI R
  input  logic [DATA_BIT_WIDTH-1:0]     i_rdata,
  input  logic [1:0]                    i_rresp,
  input  logic                          i_rvalid,
  output logic                          o_rready,
  // debug
  output logic [2:0]                    o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_e;

  // Every handshake in this block is plain valid/ready: a transfer happens on the
  // rising edge where both are high; valid never drops before that edge and the
  // payload is held stable while valid is high.

  state_e                        state_q, state_d;
  logic [ADDR_BIT_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_BIT_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_BIT_WIDTH/8-1:0]   wstrb_q, wstrb_d;
  logic                          is_wr_q, is_wr_d;
  logic [DATA_BIT_WIDTH-1:0]     rdata_q, rdata_d;
  logic [1:0]                    resp_q, resp_d;
  logic [7:0]                    err_cnt_q, err_cnt_d;
  logic                          aw_done_q, aw_done_d;
  logic                          w_done_q, w_done_d;
  logic                          capture;

  always_ff @(posedge i_clk or posedge i_async_rst) begin
    if (i_async_rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      is_wr_q   <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      err_cnt_q <= 8'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      is_wr_q   <= is_wr_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      err_cnt_q <= err_cnt_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    is_wr_d   = is_wr_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    err_cnt_d = err_cnt_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_cmd_valid) begin
          addr_d  = i_cmd_addr;
          wdata_d = i_cmd_wdata;
          wstrb_d = i_cmd_wstrb;
          is_wr_d = i_cmd_is_wr;
          state_d = i_cmd_is_wr ? WR_REQ : RD_ADDR;
        end
      end
      WR_REQ: begin
        // AW and W complete independently; leave only once both have transferred.
        aw_done_d = aw_done_q | i_awready;
        w_done_d  = w_done_q | i_wready;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: begin
        if (i_bvalid) begin
          resp_d  = i_bresp;
          rdata_d = '0;
          capture = 1'b1;
          state_d = RSP;
        end
      end
      RD_ADDR: begin
        if (i_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (i_rvalid) begin
          rdata_d = i_rdata;
          resp_d  = i_rresp;
          capture = 1'b1;
          state_d = RSP;
        end
      end
      RSP: begin
        if (i_rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (capture && (resp_d != 2'b00) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Handshake outputs decode straight from the state register so reset kills them at once.
  assign o_cmd_ready = (state_q == IDLE);
  assign o_awvalid   = (state_q == WR_REQ) && !aw_done_q;
  assign o_wvalid    = (state_q == WR_REQ) && !w_done_q;
  assign o_bready    = (state_q == WR_RESP);
  assign o_arvalid   = (state_q == RD_ADDR);
  assign o_rready    = (state_q == RD_DATA);
  assign o_rsp_valid = (state_q == RSP);

  assign o_awaddr    = addr_q;
  assign o_araddr    = addr_q;
  assign o_awprot    = 3'b000;
  assign o_arprot    = 3'b000;
  assign o_wdata     = wdata_q;
  assign o_wstrb     = wstrb_q;
  assign o_rsp_is_wr = is_wr_q;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_resp  = resp_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_axi4_lite_cmd_mst.sv
// Directed plus randomized bench for axi4_lite_cmd_mst: the bench acts as command source,
// AXI slave (with its own memory) and response sink, against a word-level reference model.
module tb_axi4_lite_cmd_mst;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          i_cmd_valid, o_cmd_ready, i_cmd_is_wr;
  logic [AW-1:0] i_cmd_addr;
  logic [DW-1:0] i_cmd_wdata;
  logic [SW-1:0] i_cmd_wstrb;
  logic          o_rsp_valid, i_rsp_ready, o_rsp_is_wr;
  logic [DW-1:0] o_rsp_rdata;
  logic [1:0]    o_rsp_resp;
  logic [7:0]    o_err_cnt;
  logic [AW-1:0] o_awaddr, o_araddr;
  logic [2:0]    o_awprot, o_arprot, o_dbg_state;
  logic          o_awvalid, i_awready, o_wvalid, i_wready;
  logic [DW-1:0] o_wdata, i_rdata;
  logic [SW-1:0] o_wstrb;
  logic [1:0]    i_bresp, i_rresp;
  logic          i_bvalid, o_bready, o_arvalid, i_arready, i_rvalid, o_rready;

  axi4_lite_cmd_mst #(.ADDR_BIT_WIDTH(AW), .DATA_BIT_WIDTH(DW)) dut (
    .i_clk(clk), .i_async_rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_is_wr(i_cmd_is_wr),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_is_wr(o_rsp_is_wr),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_resp(o_rsp_resp), .o_err_cnt(o_err_cnt),
    .o_awaddr(o_awaddr), .o_awprot(o_awprot), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
    .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
    .o_araddr(o_araddr), .o_arprot(o_arprot), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
    .o_dbg_state(o_dbg_state)
  );

  // scoreboard / reference model
  int            n_chk = 0;
  int            n_fail = 0;
  int            exp_err = 0;
  int            lat;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem[16];
  logic [DW-1:0] slv_mem[16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_chk++;
    n_fail++;
    $error("FAIL %s: cycle budget expired", tag);
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r = old;
    for (int b = 0; b < SW; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    i_cmd_valid = 1'b0; i_cmd_is_wr = 1'b0; i_cmd_addr = '0; i_cmd_wdata = '0; i_cmd_wstrb = '0;
    i_rsp_ready = 1'b0; i_awready = 1'b0; i_wready = 1'b0; i_bresp = 2'b00; i_bvalid = 1'b0;
    i_arready = 1'b0; i_rdata = '0; i_rresp = 2'b00; i_rvalid = 1'b0;
  endtask

  // Drivers: every task starts and ends just after a falling edge.
  task automatic issue_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s);
    chk("cmd_ready_idle", o_cmd_ready, 1'b1);
    i_cmd_valid = 1'b1; i_cmd_is_wr = wr; i_cmd_addr = a; i_cmd_wdata = d; i_cmd_wstrb = s;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    i_cmd_is_wr = 1'($urandom); i_cmd_addr = AW'($urandom);
    i_cmd_wdata = $urandom; i_cmd_wstrb = SW'($urandom);
  endtask

  task automatic check_rsp(input logic wr, input logic [1:0] resp, input int hold,
                           input logic pend_rd, input logic [AW-1:0] pend_addr);
    logic [DW-1:0] exp_d;
    if (resp != 2'b00 && exp_err < 255) exp_err++;
    exp_d = exp_q.pop_front();
    for (int i = 0; i <= hold; i++) begin
      chk("rsp_valid", o_rsp_valid, 1'b1);
      chk("rsp_is_wr", o_rsp_is_wr, wr);
      chk("rsp_rdata", o_rsp_rdata, exp_d);
      chk("rsp_resp", o_rsp_resp, resp);
      chk("err_cnt", o_err_cnt, exp_err);
      chk("cmd_ready_busy", o_cmd_ready, 1'b0);
      if (pend_rd) begin
        i_cmd_valid = 1'b1; i_cmd_is_wr = 1'b0; i_cmd_addr = pend_addr;
      end
      i_rsp_ready = (i == hold);
      @(negedge clk);
      lat++;
    end
    i_rsp_ready = 1'b0;
    chk("rsp_valid_drop", o_rsp_valid, 1'b0);
    chk("cmd_ready_back", o_cmd_ready, 1'b1);
  endtask

  task automatic run_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                           input logic [1:0] br, input int aw_dly, input int w_dly,
                           input int b_dly, input int hold);
    logic          aw_p = 1'b1;
    logic          w_p = 1'b1;
    logic [AW-1:0] slv_a = '0;
    logic [DW-1:0] slv_wd = '0;
    logic [SW-1:0] slv_ws = '0;
    exp_q.push_back('0);
    if (br == 2'b00) ref_mem[a] = merge(ref_mem[a], d, s);
    issue_cmd(1'b1, a, d, s);
    lat = 0;
    for (int cyc = 0; aw_p || w_p; cyc++) begin
      if (cyc > 40) begin timeout("wr_req_timeout"); break; end
      chk("awvalid", o_awvalid, aw_p);
      chk("wvalid", o_wvalid, w_p);
      chk("bready_early", o_bready, 1'b0);
      if (aw_p) begin
        chk("awaddr", o_awaddr, a);
        chk("awprot", o_awprot, 3'b000);
      end
      if (w_p) begin
        chk("wdata", o_wdata, d);
        chk("wstrb", o_wstrb, s);
      end
      i_awready = (cyc >= aw_dly);
      i_wready  = (cyc >= w_dly);
      if (aw_p && i_awready) begin aw_p = 1'b0; slv_a = o_awaddr; end
      if (w_p && i_wready) begin w_p = 1'b0; slv_wd = o_wdata; slv_ws = o_wstrb; end
      @(negedge clk);
      lat++;
    end
    i_awready = 1'b0; i_wready = 1'b0;
    if (br == 2'b00) slv_mem[slv_a] = merge(slv_mem[slv_a], slv_wd, slv_ws);
    for (int c = 0; c <= b_dly; c++) begin
      chk("bready", o_bready, 1'b1);
      chk("awvalid_done", o_awvalid, 1'b0);
      chk("wvalid_done", o_wvalid, 1'b0);
      i_bvalid = (c == b_dly);
      i_bresp  = (c == b_dly) ? br : 2'b00;
      @(negedge clk);
      lat++;
    end
    i_bvalid = 1'b0; i_bresp = 2'b00;
    check_rsp(1'b1, br, hold, 1'b0, '0);
    if (aw_dly == 0 && w_dly == 0 && b_dly == 0 && hold == 0) chk("wr_latency", lat, 3);
  endtask

  task automatic run_read(input logic [AW-1:0] a, input logic [1:0] rr, input int ar_dly,
                          input int r_dly, input int hold, input logic early_rv,
                          input logic pend_rd, input logic [AW-1:0] pend_addr);
    logic [AW-1:0] slv_a = '0;
    logic          done = 1'b0;
    exp_q.push_back(ref_mem[a]);
    issue_cmd(1'b0, a, $urandom, SW'($urandom));
    lat = 0;
    for (int cyc = 0; !done; cyc++) begin
      if (cyc > 40) begin timeout("rd_addr_timeout"); break; end
      chk("arvalid", o_arvalid, 1'b1);
      chk("araddr", o_araddr, a);
      chk("arprot", o_arprot, 3'b000);
      chk("rready_early", o_rready, 1'b0);
      i_arready = (cyc >= ar_dly);
      if (early_rv) begin i_rvalid = 1'b1; i_rdata = $urandom; i_rresp = 2'b11; end
      if (i_arready) begin done = 1'b1; slv_a = o_araddr; end
      @(negedge clk);
      lat++;
    end
    i_arready = 1'b0; i_rvalid = 1'b0;
    for (int c = 0; c <= r_dly; c++) begin
      chk("rready", o_rready, 1'b1);
      chk("arvalid_done", o_arvalid, 1'b0);
      i_rvalid = (c == r_dly);
      i_rdata  = (c == r_dly) ? slv_mem[slv_a] : $urandom;
      i_rresp  = (c == r_dly) ? rr : 2'b00;
      @(negedge clk);
      lat++;
    end
    i_rvalid = 1'b0; i_rresp = 2'b00;
    check_rsp(1'b0, rr, hold, pend_rd, pend_addr);
    if (ar_dly == 0 && r_dly == 0 && hold == 0) chk("rd_latency", lat, 3);
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [1:0]    r;
    for (int i = 0; i < 16; i++) begin ref_mem[i] = '0; slv_mem[i] = '0; end
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_cmd_ready", o_cmd_ready, 1'b1);
    chk("rst_valids", {o_awvalid, o_wvalid, o_arvalid, o_rsp_valid}, 4'b0000);
    chk("rst_readies", {o_bready, o_rready}, 2'b00);
    chk("rst_regs", {o_awaddr, o_araddr, o_wdata, o_wstrb, o_rsp_rdata, o_rsp_resp}, '0);
    chk("rst_err_cnt", o_err_cnt, 8'd0);
    rst = 1'b0;
    @(negedge clk);

    // two back-to-back writes with an always-ready slave
    run_write(4'h0, 32'h1234_5678, 4'hF, 2'b00, 0, 0, 0, 0);
    run_write(4'h1, 32'h8765_4321, 4'hF, 2'b00, 0, 0, 0, 0);
    // read back with i_rvalid forced high during the address phase
    run_read(4'h0, 2'b00, 0, 0, 0, 1'b1, 1'b0, '0);
    // W handshake three cycles after AW
    run_write(4'h2, 32'hCAFE_F00D, 4'hF, 2'b00, 0, 3, 0, 0);
    // W before AW, then delayed B
    run_write(4'h3, 32'hA5A5_5A5A, 4'b0101, 2'b00, 2, 0, 2, 0);
    // response stalled for 5 cycles with a read command waiting behind it
    run_read(4'h1, 2'b00, 0, 0, 5, 1'b0, 1'b1, 4'h2);
    run_read(4'h2, 2'b00, 1, 2, 0, 1'b0, 1'b0, '0);
    // zero strobes pass through and leave memory untouched
    run_write(4'h0, 32'hFFFF_FFFF, 4'h0, 2'b00, 0, 0, 0, 0);
    run_read(4'h0, 2'b00, 0, 0, 0, 1'b0, 1'b0, '0);

    // randomized mix of commands, delays and responses
    for (int n = 0; n < 40; n++) begin
      a = AW'($urandom_range(0, 15));
      d = $urandom;
      s = ($urandom_range(0, 4) == 0) ? '0 : SW'($urandom);
      r = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 1) == 1)
        run_write(a, d, s, r, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 2), $urandom_range(0, 2));
      else
        run_read(a, r, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                 1'($urandom), 1'b0, '0);
    end

    // 300 error writes drive the counter into saturation
    for (int n = 0; n < 300; n++) begin
      run_write(AW'($urandom_range(0, 15)), $urandom, SW'($urandom), 2'b10, 0, 0, 0, 0);
    end
    chk("err_cnt_sat", o_err_cnt, 8'd255);

    // asynchronous reset in the middle of a write request
    issue_cmd(1'b1, 4'h5, 32'hDEAD_BEEF, 4'hF);
    chk("abort_awvalid_pre", o_awvalid, 1'b1);
    chk("abort_wvalid_pre", o_wvalid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort_awvalid", o_awvalid, 1'b0);
    chk("abort_wvalid", o_wvalid, 1'b0);
    chk("abort_cmd_ready", o_cmd_ready, 1'b1);
    chk("abort_err_cnt", o_err_cnt, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_err = 0;
    for (int c = 0; c < 5; c++) begin
      chk("abort_no_rsp", o_rsp_valid, 1'b0);
      chk("abort_idle", o_cmd_ready, 1'b1);
      @(negedge clk);
    end
    run_read(4'h1, 2'b00, 0, 0, 0, 1'b0, 1'b0, '0);
    run_write(4'h6, 32'h0BAD_C0DE, 4'hF, 2'b01, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
